key_text_writer: RTL and testbench
==================================

Name: key_text_writer

Overview:
- Consumes the ASCII stream produced by the PS/2 keyboard decoder, which presents a byte plus a one-cycle new-key strobe.
- Turns each key into text-mode video RAM writes and maintains a cursor (col,row).
- Implements hardware scrolling through a circular row offset, so a scroll never copies screen contents; only the newly exposed line is cleared.
- Sits between the keyboard decoder and the character RAM write port; the character generator reads scroll_row to rotate the display.

Parameters:
- COLS, 80, characters per row.
- ROWS, 30, rows per screen.
- ADDR_W, 12, video RAM address width; COLS*ROWS must be <= 2**ADDR_W.
- BLANK_CHAR, 8'h20, fill character for clears and backspace.

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- key_ascii  in  8  ASCII code, valid when key_valid=1.
- key_valid  in  1  one-cycle new-key strobe.
- vram_we  out  1  video RAM write enable.
- vram_addr  out  ADDR_W  write address = phys_row*COLS + col.
- vram_wdata  out  8  write data.
- cursor_col  out  clog2(COLS)  logical cursor column.
- cursor_row  out  clog2(ROWS)  logical cursor row (0 = top of screen).
- scroll_row  out  clog2(ROWS)  physical RAM row displayed as the top line.
- busy  out  1  high while a multi-cycle clear is running.
- key_dropped  out  1  one-cycle pulse when a key is lost.

Behaviour:
- Reset: the clock and reset are already decided as one clock (sys_clk); reset is synchronous and active-high.
- Reset values: cursor 0,0; scroll_row 0; vram_we 0; vram_addr 0; vram_wdata BLANK_CHAR; key_dropped 0; pending empty; state CLEAR_ALL with counter 0; busy 1.
- Reset asserted mid-operation aborts everything and restarts CLEAR_ALL from address 0.
- phys_row = (scroll_row + cursor_row) mod ROWS, computed by compare-and-subtract; no divider.
- Pending register (1 entry):
  - key_valid with pending empty, or emptied in the same cycle: capture the key.
  - key_valid with pending occupied and not consumed this cycle: discard the key and pulse key_dropped for 1 cycle.
- States:
  - CLEAR_ALL: one write per cycle of BLANK_CHAR to addresses 0..COLS*ROWS-1, then IDLE. busy=1.
  - IDLE: if pending is valid, consume it and decode:
    - Printable (0x20..0x7E or 0xA0..0xFF): register vram_we=1, addr=cursor position, data=key. Advance col; if col==COLS-1, do NEWLINE instead of incrementing.
    - 0x0D: NEWLINE.
    - 0x08 with col>0: col-1, then write BLANK_CHAR at the new position.
    - 0x08 with col==0 and row>0: row-1, col=COLS-1, write BLANK_CHAR there.
    - 0x08 at 0,0: no action.
    - Any other code: consumed, no action.
  - NEWLINE: col=0.
    - If row<ROWS-1: row+1, no write.
    - Else: row stays ROWS-1, scroll_row wraps +1 (ROWS-1 -> 0), enter CLEAR_LINE.
  - CLEAR_LINE: COLS consecutive writes of BLANK_CHAR to the new bottom physical row (old scroll_row value), col index 0..COLS-1, then IDLE. busy=1.
- Latency: strobe sampled at edge E0 → pending. At E1 IDLE consumes it; vram_we/addr/data and cursor are registered. The RAM sees the write at E2.
- vram_we is high for exactly 1 cycle per character write.
- Back-to-back strobes on consecutive cycles in IDLE: both are accepted, because pending empties at E1.
- A printable key at col COLS-1 of the last row writes the char, scrolls, and clears the line.

Optional Feature:
- Macro: KEY_TEXT_WRITER_CURSOR_BLINK_EN.
- When defined:
  - Adds parameter BLINK_DIV (default 25_000_000) and output cursor_on.
  - cursor_on toggles every BLINK_DIV cycles.
  - It is forced to 1 and the counter restarts on any accepted key.
  - Reset value of cursor_on is 1.
- When undefined: the port is absent and there is no counter logic.

Decomposition:
- Package key_text_pkg holds:
  - ASCII constants: CR 8'h0D, BS 8'h08, printable range limits.
  - State enum: CLEAR_ALL, IDLE, NEWLINE, CLEAR_LINE.
- Sub-module cursor_blinker holds the optional blink counter, instantiated only under the macro.
- Address arithmetic stays inline.

Test Plan:
- Reset, then release → exactly 2400 writes of 0x20 to addrs 0..2399, busy=1 throughout, then busy=0 with cursor 0,0.
- key 0x41 at 0,0 → 1 write addr 0 data 0x41 two edges after the strobe; cursor 1,0.
- 80 keys 0x61 → last write addr 79; cursor 0,1. Then 0x08 → cursor 79,0, write 0x20 to addr 79.
- Cursor at row 29, 0x0D → scroll_row 1, 80 writes of 0x20 to addrs 0..79, cursor 0,29. Then 0xD1 → write addr 0 data 0xD1 (physical row 0).
- 3 strobes during CLEAR_LINE → first held and written after the clear; second and third each pulse key_dropped.
- Reset asserted mid-CLEAR_LINE → writes restart at addr 0, scroll_row 0, cursor 0,0.

Source files
------------

// File: rtl/key_text_writer_pkg.sv
// rtl/key_text_writer_pkg.sv - ASCII constants, FSM states and decode helper for key_text_writer
package key_text_pkg;

    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_BS     = 8'h08;
    localparam logic [7:0] PRINT_LO     = 8'h20;
    localparam logic [7:0] PRINT_HI     = 8'h7E;
    localparam logic [7:0] PRINT_EXT_LO = 8'hA0;

    typedef enum logic [1:0] {
        CLEAR_ALL  = 2'd0,
        IDLE       = 2'd1,
        NEWLINE    = 2'd2,
        CLEAR_LINE = 2'd3
    } state_t;

    // Codes that land on screen as glyphs: 7-bit printable plus the upper Latin-1 half.
    function automatic logic is_printable(input logic [7:0] c);
        return ((c >= PRINT_LO) && (c <= PRINT_HI)) || (c >= PRINT_EXT_LO);
    endfunction

endpackage

// File: rtl/key_text_writer_if.sv
// rtl/key_text_writer_if.sv - key stream in and video RAM write port out, with modports
interface key_text_writer_if #(
    parameter int ADDR_W = 12
);

    logic [7:0]        key_ascii;
    logic              key_valid;
    logic              vram_we;
    logic [ADDR_W-1:0] vram_addr;
    logic [7:0]        vram_wdata;

    // The writer consumes keys and masters the RAM write port.
    modport master (
        input  key_ascii,
        input  key_valid,
        output vram_we,
        output vram_addr,
        output vram_wdata
    );

    // Keyboard decoder / RAM side.
    modport slave (
        output key_ascii,
        output key_valid,
        input  vram_we,
        input  vram_addr,
        input  vram_wdata
    );

endinterface

// File: rtl/key_text_writer_cursor_blinker.sv
// rtl/key_text_writer_cursor_blinker.sv - cursor blink divider, restarted on every accepted key
module cursor_blinker #(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic sys_clk,
    input  logic reset,
    input  logic restart,
    output logic cursor_on
);

    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Toggle every BLINK_DIV cycles; a keypress shows the cursor solid and restarts the period.
    always_ff @(posedge sys_clk) begin
        if (reset || restart) begin
            cnt       <= '0;
            cursor_on <= 1'b1;
        end else if (cnt == CNT_LAST) begin
            cnt       <= '0;
            cursor_on <= ~cursor_on;
        end else begin
            cnt       <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/key_text_writer.sv
// rtl/key_text_writer.sv - keys to text-mode VRAM writes with cursor and circular-scroll; optional KEY_TEXT_WRITER_CURSOR_BLINK_EN
module key_text_writer
    import key_text_pkg::*;
#(
    parameter int         COLS       = 80,
    parameter int         ROWS       = 30,
    parameter int         ADDR_W     = 12,
    parameter logic [7:0] BLANK_CHAR = 8'h20
`ifdef KEY_TEXT_WRITER_CURSOR_BLINK_EN
    ,
    parameter int         BLINK_DIV  = 25_000_000
`endif
) (
    input  logic                     sys_clk,
    input  logic                     reset,
    key_text_writer_if.master        tw_bus,
    output logic [$clog2(COLS)-1:0]  cursor_col,
    output logic [$clog2(ROWS)-1:0]  cursor_row,
    output logic [$clog2(ROWS)-1:0]  scroll_row,
    output logic                     busy,
    output logic                     key_dropped
`ifdef KEY_TEXT_WRITER_CURSOR_BLINK_EN
    ,
    output logic                     cursor_on
`endif
);

    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic [ROW_W:0]    ROWS_S     = (ROW_W + 1)'(ROWS);
    localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LINE_LAST  = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] TOTAL_LAST = ADDR_W'(COLS * ROWS - 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_n;
    logic [COL_W-1:0]  col_n;
    logic [ROW_W-1:0]  row_n, scroll_n;
    logic              we_q, we_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [7:0]        wdata_q, wdata_n;

    logic              pend_valid;
    logic [7:0]        pend_data;
    logic              consume;

    logic [ROW_W:0]    row_sum;
    logic [ROW_W-1:0]  phys_row, prev_phys_row;
    logic [ADDR_W-1:0] row_base, prev_row_base, cur_addr;

    assign tw_bus.vram_we    = we_q;
    assign tw_bus.vram_addr  = addr_q;
    assign tw_bus.vram_wdata = wdata_q;
    assign busy    = (state == CLEAR_ALL) || (state == CLEAR_LINE);
    assign consume = (state == IDLE) && pend_valid;

    // Map logical cursor row onto the circular physical row; compare-and-subtract replaces a modulo.
    always_comb begin
        row_sum = {1'b0, scroll_row} + {1'b0, cursor_row};
        if (row_sum >= ROWS_S) begin
            phys_row = ROW_W'(row_sum - ROWS_S);
        end else begin
            phys_row = row_sum[ROW_W-1:0];
        end
        prev_phys_row = (phys_row == '0) ? ROW_LAST : phys_row - ROW_W'(1);
        row_base      = ADDR_W'(phys_row) * COLS_A;
        prev_row_base = ADDR_W'(prev_phys_row) * COLS_A;
        cur_addr      = row_base + ADDR_W'(cursor_col);
    end

    // Single-entry key holding register; a key arriving while it is full and not draining is lost.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            pend_valid  <= 1'b0;
            pend_data   <= 8'h00;
            key_dropped <= 1'b0;
        end else begin
            key_dropped <= 1'b0;
            if (tw_bus.key_valid) begin
                if (!pend_valid || consume) begin
                    pend_valid <= 1'b1;
                    pend_data  <= tw_bus.key_ascii;
                end else begin
                    key_dropped <= 1'b1;
                end
            end else if (consume) begin
                pend_valid <= 1'b0;
            end
        end
    end

    // Next-state and write-port decode. During CLEAR_LINE the cursor sits on the last logical
    // row, whose physical row is the old scroll_row, so row_base already points at the line to wipe.
    always_comb begin
        state_n   = state;
        clr_cnt_n = clr_cnt;
        col_n     = cursor_col;
        row_n     = cursor_row;
        scroll_n  = scroll_row;
        we_n      = 1'b0;
        addr_n    = addr_q;
        wdata_n   = wdata_q;
        case (state)
            CLEAR_ALL: begin
                we_n    = 1'b1;
                addr_n  = clr_cnt;
                wdata_n = BLANK_CHAR;
                if (clr_cnt == TOTAL_LAST) begin
                    clr_cnt_n = '0;
                    state_n   = IDLE;
                end else begin
                    clr_cnt_n = clr_cnt + ADDR_W'(1);
                end
            end
            IDLE: begin
                if (pend_valid) begin
                    if (is_printable(pend_data)) begin
                        we_n    = 1'b1;
                        addr_n  = cur_addr;
                        wdata_n = pend_data;
                        if (cursor_col == COL_LAST) begin
                            state_n = NEWLINE;
                        end else begin
                            col_n = cursor_col + COL_W'(1);
                        end
                    end else if (pend_data == ASCII_CR) begin
                        state_n = NEWLINE;
                    end else if (pend_data == ASCII_BS) begin
                        if (cursor_col != '0) begin
                            col_n   = cursor_col - COL_W'(1);
                            we_n    = 1'b1;
                            addr_n  = cur_addr - ADDR_W'(1);
                            wdata_n = BLANK_CHAR;
                        end else if (cursor_row != '0) begin
                            row_n   = cursor_row - ROW_W'(1);
                            col_n   = COL_LAST;
                            we_n    = 1'b1;
                            addr_n  = prev_row_base + LINE_LAST;
                            wdata_n = BLANK_CHAR;
                        end
                    end
                end
            end
            NEWLINE: begin
                col_n = '0;
                if (cursor_row != ROW_LAST) begin
                    row_n   = cursor_row + ROW_W'(1);
                    state_n = IDLE;
                end else begin
                    scroll_n  = (scroll_row == ROW_LAST) ? '0 : scroll_row + ROW_W'(1);
                    clr_cnt_n = '0;
                    state_n   = CLEAR_LINE;
                end
            end
            CLEAR_LINE: begin
                we_n    = 1'b1;
                addr_n  = row_base + clr_cnt;
                wdata_n = BLANK_CHAR;
                if (clr_cnt == LINE_LAST) begin
                    clr_cnt_n = '0;
                    state_n   = IDLE;
                end else begin
                    clr_cnt_n = clr_cnt + ADDR_W'(1);
                end
            end
            default: begin
                state_n   = CLEAR_ALL;
                clr_cnt_n = '0;
            end
        endcase
    end

    // State, cursor, scroll offset and registered write port.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state      <= CLEAR_ALL;
            clr_cnt    <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
            scroll_row <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= BLANK_CHAR;
        end else begin
            state      <= state_n;
            clr_cnt    <= clr_cnt_n;
            cursor_col <= col_n;
            cursor_row <= row_n;
            scroll_row <= scroll_n;
            we_q       <= we_n;
            addr_q     <= addr_n;
            wdata_q    <= wdata_n;
        end
    end

`ifdef KEY_TEXT_WRITER_CURSOR_BLINK_EN
    logic key_accept;
    assign key_accept = tw_bus.key_valid && (!pend_valid || consume);

    cursor_blinker #(
        .BLINK_DIV (BLINK_DIV)
    ) u_cursor_blinker (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .restart   (key_accept),
        .cursor_on (cursor_on)
    );
`endif

endmodule

// File: tb/tb_key_text_writer.sv
// tb/tb_key_text_writer.sv - self-checking bench for key_text_writer against a screen model
module tb_key_text_writer;

    localparam int COLS = 80;
    localparam int ROWS = 30;

    logic       sys_clk = 1'b0;
    logic       reset   = 1'b1;
    logic [6:0] cursor_col;
    logic [4:0] cursor_row;
    logic [4:0] scroll_row;
    logic       busy;
    logic       key_dropped;

    key_text_writer_if #(.ADDR_W(12)) tw_bus ();

    key_text_writer #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .ADDR_W     (12),
        .BLANK_CHAR (8'h20)
    ) dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .tw_bus      (tw_bus),
        .cursor_col  (cursor_col),
        .cursor_row  (cursor_row),
        .scroll_row  (scroll_row),
        .busy        (busy),
        .key_dropped (key_dropped)
    );

    always #5 sys_clk = ~sys_clk;

    int tests = 0;
    int fails = 0;
    int drop_cnt = 0;
    logic [19:0] got_q[$];
    logic [19:0] exp_q[$];
    int m_col, m_row, m_scroll;

    // Capture every RAM write and every drop pulse away from the active edge.
    always @(negedge sys_clk) begin
        if (tw_bus.vram_we) got_q.push_back({tw_bus.vram_addr, tw_bus.vram_wdata});
        if (key_dropped) drop_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic int phys(input int r);
        return (m_scroll + r) % ROWS;
    endfunction

    task automatic m_write(input int a, input int d);
        logic [11:0] aa;
        logic [7:0]  dd;
        aa = a[11:0];
        dd = d[7:0];
        exp_q.push_back({aa, dd});
    endtask

    task automatic m_reset();
        m_col = 0;
        m_row = 0;
        m_scroll = 0;
        for (int a = 0; a < COLS * ROWS; a++) m_write(a, 32);
    endtask

    task automatic m_newline();
        m_col = 0;
        if (m_row < ROWS - 1) begin
            m_row++;
        end else begin
            for (int c = 0; c < COLS; c++) m_write(m_scroll * COLS + c, 32);
            m_scroll = (m_scroll + 1) % ROWS;
        end
    endtask

    task automatic m_key(input logic [7:0] k);
        int ki;
        ki = int'(k);
        if ((ki >= 32 && ki <= 126) || ki >= 160) begin
            m_write(phys(m_row) * COLS + m_col, ki);
            if (m_col == COLS - 1) m_newline();
            else m_col++;
        end else if (ki == 13) begin
            m_newline();
        end else if (ki == 8) begin
            if (m_col > 0) begin
                m_col--;
                m_write(phys(m_row) * COLS + m_col, 32);
            end else if (m_row > 0) begin
                m_row--;
                m_col = COLS - 1;
                m_write(phys(m_row) * COLS + m_col, 32);
            end
        end
    endtask

    task automatic send_key(input logic [7:0] k);
        tw_bus.key_ascii = k;
        tw_bus.key_valid = 1'b1;
        tick();
        tw_bus.key_valid = 1'b0;
    endtask

    task automatic settle();
        int n;
        repeat (3) tick();
        n = 0;
        while (busy && n < 5000) begin
            tick();
            n++;
        end
        check("settle_busy", busy, 0);
        repeat (2) tick();
    endtask

    task automatic do_key(input logic [7:0] k);
        send_key(k);
        m_key(k);
        settle();
    endtask

    task automatic cmp_writes(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, "_write"}, got_q[i], exp_q[i]);
            if (got_q[i] !== exp_q[i]) break;
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic cmp_cursor(input string tag);
        check({tag, "_col"}, cursor_col, m_col);
        check({tag, "_row"}, cursor_row, m_row);
        check({tag, "_scroll"}, scroll_row, m_scroll);
    endtask

    initial begin
        logic [7:0] k;
        int cls;

        tw_bus.key_ascii = 8'h00;
        tw_bus.key_valid = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        check("rst_col", cursor_col, 0);
        check("rst_row", cursor_row, 0);
        check("rst_scroll", scroll_row, 0);
        check("rst_we", tw_bus.vram_we, 0);
        check("rst_addr", tw_bus.vram_addr, 0);
        check("rst_wdata", tw_bus.vram_wdata, 8'h20);
        check("rst_busy", busy, 1);
        check("rst_drop", key_dropped, 0);

        got_q.delete();
        reset = 1'b0;
        m_reset();
        tick();
        check("clr_first_we", tw_bus.vram_we, 1);
        check("clr_first_addr", tw_bus.vram_addr, 0);
        check("clr_busy", busy, 1);
        settle();
        cmp_writes("clear_all");
        cmp_cursor("after_clear");

        tw_bus.key_ascii = 8'h41;
        tw_bus.key_valid = 1'b1;
        tick();
        tw_bus.key_valid = 1'b0;
        check("lat_e0_we", tw_bus.vram_we, 0);
        tick();
        check("lat_e1_we", tw_bus.vram_we, 1);
        check("lat_e1_addr", tw_bus.vram_addr, 0);
        check("lat_e1_data", tw_bus.vram_wdata, 8'h41);
        check("lat_e1_col", cursor_col, 1);
        tick();
        check("lat_e2_we", tw_bus.vram_we, 0);
        m_key(8'h41);
        settle();
        cmp_writes("key_a");

        do_key(8'h08);
        for (int i = 0; i < COLS; i++) do_key(8'h61);
        if (got_q.size() > 0) check("fill_last_addr", got_q[got_q.size() - 1][19:8], 79);
        check("fill_col", cursor_col, 0);
        check("fill_row", cursor_row, 1);
        cmp_writes("fill_row");
        do_key(8'h08);
        check("bs_wrap_col", cursor_col, 79);
        check("bs_wrap_row", cursor_row, 0);
        if (got_q.size() > 0) check("bs_wrap_write", got_q[got_q.size() - 1], {12'd79, 8'h20});
        cmp_writes("bs_wrap");

        while (m_row < ROWS - 1) do_key(8'h0D);
        do_key(8'h0D);
        check("scroll1_scroll", scroll_row, 1);
        check("scroll1_row", cursor_row, 29);
        cmp_writes("scroll1");
        do_key(8'hD1);
        check("after_scroll_write", got_q.size() > 0 ? got_q[got_q.size() - 1] : 20'hFFFFF, {12'd0, 8'hD1});
        cmp_writes("after_scroll");
        cmp_cursor("after_scroll");

        drop_cnt = 0;
        send_key(8'h0D);
        m_key(8'h0D);
        repeat (4) tick();
        check("drop_busy", busy, 1);
        send_key(8'h78);
        check("drop_x_pulse", key_dropped, 0);
        send_key(8'h79);
        check("drop_y_pulse", key_dropped, 1);
        send_key(8'h7A);
        check("drop_z_pulse", key_dropped, 1);
        m_key(8'h78);
        settle();
        check("drop_count", drop_cnt, 2);
        cmp_writes("drop");
        cmp_cursor("drop");

        do_key(8'h0D);
        tw_bus.key_ascii = 8'h70;
        tw_bus.key_valid = 1'b1;
        tick();
        tw_bus.key_ascii = 8'h71;
        tick();
        tw_bus.key_valid = 1'b0;
        m_key(8'h70);
        m_key(8'h71);
        settle();
        check("b2b_no_drop", drop_cnt, 2);
        cmp_writes("b2b");
        cmp_cursor("b2b");

        for (int i = 0; i < 300; i++) begin
            cls = int'($urandom_range(0, 9));
            if (cls <= 5) begin
                k = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(32, 126)) : 8'($urandom_range(160, 255));
            end else if (cls <= 7) begin
                k = 8'h0D;
            end else if (cls == 8) begin
                k = 8'h08;
            end else begin
                k = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(127, 159));
            end
            do_key(k);
            if (i % 30 == 29) begin
                cmp_writes("rand");
                cmp_cursor("rand");
            end
        end
        check("rand_no_drop", drop_cnt, 2);

        while (m_row < ROWS - 1) do_key(8'h0D);
        send_key(8'h0D);
        repeat (20) tick();
        check("midclr_busy", busy, 1);
        reset = 1'b1;
        tick();
        check("midrst_scroll", scroll_row, 0);
        check("midrst_col", cursor_col, 0);
        check("midrst_row", cursor_row, 0);
        check("midrst_we", tw_bus.vram_we, 0);
        got_q.delete();
        exp_q.delete();
        reset = 1'b0;
        m_reset();
        settle();
        cmp_writes("midrst_clear");
        cmp_cursor("midrst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
